// File: rtl/slider_cmd_gen.sv
// slider_cmd_gen: button sync/debounce and per-axis step strobe generator.
// Build option SLIDER_ACCEL_EN halves the repeat period after ACCEL_AFTER repeats.

module slider_axis_fsm #(
  parameter int REPEAT_DELAY_CYCLES = 7500000,
  parameter int STEP_CYCLES         = 100000,
  parameter int ACCEL_AFTER         = 16
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       i_en,
  input  logic [1:0] i_dir,
  output logic       o_plus,
  output logic       o_minus
);
  localparam int MAXP =
    (REPEAT_DELAY_CYCLES > STEP_CYCLES) ?
    REPEAT_DELAY_CYCLES : STEP_CYCLES;
  localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] DLY_LAST =
    CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST =
    CW'(STEP_CYCLES - 1);

  if (REPEAT_DELAY_CYCLES < 1 || STEP_CYCLES < 1 ||
      ACCEL_AFTER < 0) begin : g_bad_cfg
    $error("slider_axis_fsm: bad timing parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [1:0]    r_dir, w_dir_nx;
  logic          r_plus, w_plus_nx;
  logic          r_minus, w_minus_nx;
  logic [CW-1:0] w_last;

`ifdef SLIDER_ACCEL_EN
  localparam int HALF =
    (STEP_CYCLES / 2 > 0) ? STEP_CYCLES / 2 : 1;
  localparam int RW =
    (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
  localparam logic [CW-1:0] FAST_LAST = CW'(HALF - 1);
  localparam logic [RW-1:0] REP_MAX = RW'(ACCEL_AFTER);

  logic [RW-1:0] r_rep, w_rep_nx;

  assign w_last = (r_rep == REP_MAX) ? FAST_LAST : STEP_LAST;
`else
  assign w_last = STEP_LAST;
`endif

  assign o_plus  = r_plus;
  assign o_minus = r_minus;

  // state, counter, latched direction and registered strobes
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= '0;
      r_plus  <= 1'b0;
      r_minus <= 1'b0;
`ifdef SLIDER_ACCEL_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
      r_plus  <= w_plus_nx;
      r_minus <= w_minus_nx;
`ifdef SLIDER_ACCEL_EN
      r_rep   <= w_rep_nx;
`endif
    end
  end

  // press / hold-delay / auto-repeat sequencing with abort on change
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir;
    w_plus_nx  = 1'b0;
    w_minus_nx = 1'b0;
`ifdef SLIDER_ACCEL_EN
    w_rep_nx   = r_rep;
`endif
    if (!i_en) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_dir_nx   = '0;
`ifdef SLIDER_ACCEL_EN
      w_rep_nx   = '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_dir != 2'b00) begin
            w_plus_nx  = i_dir[0];
            w_minus_nx = i_dir[1];
            w_dir_nx   = i_dir;
            w_cnt_nx   = '0;
            w_state_nx = S_DELAY;
          end
        end
        S_DELAY: begin
          if (i_dir != r_dir) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else if (r_cnt == DLY_LAST) begin
            w_plus_nx  = r_dir[0];
            w_minus_nx = r_dir[1];
            w_cnt_nx   = '0;
            w_state_nx = S_REPEAT;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (i_dir != r_dir) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
`ifdef SLIDER_ACCEL_EN
            w_rep_nx   = '0;
`endif
          end else if (r_cnt == w_last) begin
            w_plus_nx  = r_dir[0];
            w_minus_nx = r_dir[1];
            w_cnt_nx   = '0;
`ifdef SLIDER_ACCEL_EN
            if (r_rep != REP_MAX) w_rep_nx = r_rep + 1'b1;
`endif
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end
endmodule

module slider_cmd_gen #(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_CYCLES = 7500000,
  parameter int STEP_CYCLES         = 100000,
  parameter int ACCEL_AFTER         = 16
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [3:0] iKEY_n,
  input  logic       iEnable,
  output logic       oSlider_go,
  output logic       oSlider_back,
  output logic       oSlider_up,
  output logic       oSlider_down,
  output logic [3:0] oKey_state
);
  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("slider_cmd_gen: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [3:0]    r_sync1, r_sync2;
  logic [3:0]    r_stable;
  logic [DW-1:0] r_db_cnt [4];
  logic [3:0]    w_key;
  logic [1:0]    w_dir_x, w_dir_y;

  assign w_key      = ~r_sync2;
  assign oKey_state = r_stable;

  // two-flop synchroniser, preset to the released level
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= iKEY_n;
      r_sync2 <= r_sync1;
    end
  end

  // per-key debounce: new level must persist DEBOUNCE_CYCLES edges
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_stable <= '0;
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_key[k] == r_stable[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_stable[k] <= w_key[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // [0]=plus, [1]=minus; opposing keys cancel
  assign w_dir_x = {r_stable[1] & ~r_stable[0],
                    r_stable[0] & ~r_stable[1]};
  assign w_dir_y = {r_stable[2] & ~r_stable[3],
                    r_stable[3] & ~r_stable[2]};

  slider_axis_fsm #(
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .STEP_CYCLES        (STEP_CYCLES),
    .ACCEL_AFTER        (ACCEL_AFTER)
  ) u_x (
    .iVGA_CLK(iVGA_CLK),
    .iRST_n  (iRST_n),
    .i_en    (iEnable),
    .i_dir   (w_dir_x),
    .o_plus  (oSlider_go),
    .o_minus (oSlider_back)
  );

  slider_axis_fsm #(
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .STEP_CYCLES        (STEP_CYCLES),
    .ACCEL_AFTER        (ACCEL_AFTER)
  ) u_y (
    .iVGA_CLK(iVGA_CLK),
    .iRST_n  (iRST_n),
    .i_en    (iEnable),
    .i_dir   (w_dir_y),
    .o_plus  (oSlider_down),
    .o_minus (oSlider_up)
  );
endmodule

// File: tb/tb_slider_cmd_gen.sv
// tb_slider_cmd_gen: scoreboard bench for slider_cmd_gen.
// Reference model predicts strobes from key hold age; monitor pops and compares.
`timescale 1ns/1ps
module tb_slider_cmd_gen;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int STEP = 5;
  localparam int ACC  = 3;
  localparam int HALF = (STEP / 2 > 0) ? STEP / 2 : 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       en = 1'b1;
  logic       go, back, up, down;
  logic [3:0] ks;
  logic [3:0] w_s;

  assign w_s = {down, up, back, go};

  slider_cmd_gen #(
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(RD),
    .STEP_CYCLES        (STEP),
    .ACCEL_AFTER        (ACC)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .iKEY_n      (key_n),
    .iEnable     (en),
    .oSlider_go  (go),
    .oSlider_back(back),
    .oSlider_up  (up),
    .oSlider_down(down),
    .oKey_state  (ks)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] s;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [3:0] m_s1 = 4'hF;
  logic [3:0] m_s2 = 4'hF;
  logic [3:0] m_st = 4'h0;
  logic [3:0] m_syn, m_out;
  int         m_run[4];
  int         m_age[2] = '{-1, -1};
  int         m_ldir[2];
  int         md, mf;

  function automatic int adir(logic p, logic m);
    if (p && !m) return 1;
    if (m && !p) return -1;
    return 0;
  endfunction

  // strobe due at hold age t (t=0 is the press strobe)
  function automatic bit fires(int t);
    int r;
    if (t < RD) return 1'b0;
    r = t - RD;
`ifdef SLIDER_ACCEL_EN
    if (r > STEP * ACC) return ((r - STEP * ACC) % HALF) == 0;
`endif
    return (r % STEP) == 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_s1 = 4'hF;
      m_s2 = 4'hF;
      m_st = 4'h0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_age = '{-1, -1};
    end else begin
      m_syn = ~m_s2;
      m_out = 4'h0;
      for (int a = 0; a < 2; a++) begin
        md = (a == 0) ? adir(m_st[0], m_st[1])
                      : adir(m_st[3], m_st[2]);
        mf = 0;
        if (!en) m_age[a] = -1;
        else if (m_age[a] < 0) begin
          if (md != 0) begin
            mf = md;
            m_age[a] = 0;
            m_ldir[a] = md;
          end
        end else if (md != m_ldir[a]) m_age[a] = -1;
        else begin
          m_age[a]++;
          if (fires(m_age[a])) mf = md;
        end
        if (mf > 0) m_out[(a == 0) ? 0 : 3] = 1'b1;
        if (mf < 0) m_out[(a == 0) ? 1 : 2] = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (m_syn[k] != m_st[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_st[k] = m_syn[k];
            m_run[k] = 0;
          end
        end else m_run[k] = 0;
      end
      m_s2 = m_s1;
      m_s1 = key_n;
      if (m_out != 4'h0) sb.push_back('{cyc, m_out});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_missed: strobes %b expected at cycle %0d, missing",
               sb[0].s, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (w_s != 4'h0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: strobes %b at cycle %0d, none expected",
                 w_s, cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_cycle", cyc, e.cyc);
        chk("sb_strobes", int'(w_s), int'(e.s));
      end
    end
    chk("key_state", int'(ks), int'(m_st));
  end

  // ---------------- stimulus helpers ----------------
  int         wc[4];
  logic [3:0] wk;
  int         got_q[$];
  int         exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bit(input int b, input int budget,
                          output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (w_s[b]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic clear_watch();
    for (int k = 0; k < 4; k++) wc[k] = 0;
    wk = 4'h0;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (w_s[k]) wc[k]++;
      wk = wk | ks;
    end
  endtask

  task automatic collect(input int b, input int t0, input int n);
    got_q.delete();
    got_q.push_back(0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (w_s[b]) got_q.push_back(cyc - t0);
    end
  endtask

  task automatic cmp_offsets(input string nm);
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({nm, "_offset"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0, at, at2, rel;

  initial begin
    // reset state
    tick(2);
    chk("reset_outputs", int'({w_s, ks}), 0);
    tick(1);
    rst_n = 1'b1;
    tick(4);

    // glitch on up key
    clear_watch();
    key_n[2] = 1'b0;
    watch(3);
    key_n[2] = 1'b1;
    watch(15);
    chk("glitch_key_state", int'(wk[2]), 0);
    chk("glitch_up_strobes", wc[2], 0);

    // hold go: delay then repeat cadence
    rel = cyc;
    key_n[0] = 1'b0;
    wait_bit(0, 20, t0);
    chk("hold_first_latency", t0 - rel, 7);
    collect(0, t0, 57);
`ifdef SLIDER_ACCEL_EN
    exp_q = '{0, 20, 25, 30, 35, 37, 39, 41, 43, 45, 47,
              49, 51, 53, 55, 57};
`else
    exp_q = '{0, 20, 25, 30, 35, 40, 45, 50, 55};
`endif
    cmp_offsets("hold_go");
    key_n[0] = 1'b1;
    tick(10);
    clear_watch();
    watch(30);
    chk("release_go_strobes", wc[0], 0);

    // conflicting X keys
    key_n = 4'b1100;
    clear_watch();
    watch(30);
    chk("conflict_go", wc[0], 0);
    chk("conflict_back", wc[1], 0);
    chk("conflict_key_state", int'(ks[1:0]), 3);
    key_n = 4'b1110;
    rel = cyc;
    wait_bit(0, 20, at);
    chk("conflict_release_latency", at - rel, 7);
    key_n = 4'hF;
    tick(15);

    // reset while go held
    key_n = 4'b1110;
    tick(12);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_hold", int'({w_s, ks}), 0);
    tick(3);
    rst_n = 1'b1;
    rel = cyc;
    wait_bit(0, 20, at);
    chk("reset_release_latency", at - rel, 7);
    key_n = 4'hF;
    tick(15);

    // both axes, then enable gap
    key_n = 4'b0110;
    wait_bit(0, 20, at);
    chk("coincident_down", int'(w_s[3]), 1);
    tick(5);
    en = 1'b0;
    clear_watch();
    watch(10);
    chk("gap_strobes", wc[0] + wc[1] + wc[2] + wc[3], 0);
    en = 1'b1;
    rel = cyc;
    wait_bit(0, 5, at);
    chk("enable_restart", at - rel, 1);
    chk("enable_restart_down", int'(w_s[3]), 1);
    wait_bit(0, 30, at2);
    chk("enable_delay", at2 - at, 20);
    key_n = 4'hF;
    tick(15);

    // hold up: repeat cadence with or without acceleration
    key_n[2] = 1'b0;
    wait_bit(2, 20, t0);
    collect(2, t0, 41);
`ifdef SLIDER_ACCEL_EN
    exp_q = '{0, 20, 25, 30, 35, 37, 39, 41};
`else
    exp_q = '{0, 20, 25, 30, 35, 40};
`endif
    cmp_offsets("hold_up");
    key_n = 4'hF;
    tick(15);

    // randomized key / enable patterns
    for (int i = 0; i < 50; i++) begin
      key_n = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 5) != 0);
      tick($urandom_range(1, 50));
    end
    key_n = 4'hF;
    en = 1'b1;
    tick(40);
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
